pipeline_hazard_unit: RTL
=========================

# pipeline_hazard_unit

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline (D/E/M/WB). It detects load-use hazards and inserts a single-cycle bubble. It registers per-operand forwarding selects into the execute stage and freezes the whole pipeline while a variable-latency load waits in M. It also keeps a sticky memory-timeout flag and an optional stall counter. It sits beside the pipeline registers and drives their enable and flush inputs.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width; register 0 is hardwired zero and never hazards.
- LOAD_LAT_MAX, 8, maximum M-stage wait cycles before the timeout flag sets; must be at least 1.
- STALL_CNT_W, 16, stall counter width.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- w_d_valid, w_d_uses_rs, w_d_uses_rt  in  1 each  decode-stage instruction valid, and whether it reads rs/rt.
- w_d_rs_addr, w_d_rt_addr  in  REG_ADDR_W  decode-stage source registers.
- w_e_valid, w_e_wr_en, w_e_is_load  in  1 each  execute-stage instruction attributes.
- w_e_wr_addr  in  REG_ADDR_W  execute-stage destination register.
- w_m_valid, w_m_wr_en, w_m_is_load  in  1 each  memory-stage instruction attributes.
- w_m_wr_addr  in  REG_ADDR_W  memory-stage destination register.
- w_m_mem_ready  in  1  load data returned this cycle.
- w_stall  out  1  hold the PC and the D register.
- w_flush_e  out  1  load a bubble into the E register.
- w_mem_wait  out  1  freeze all pipeline registers.
- w_fwd_rs_sel, w_fwd_rt_sel  out  2  E-stage operand mux select: 0 = regfile, 1 = M result, 2 = WB result.
- w_mem_timeout  out  1  sticky flag; set when a load wait reaches LOAD_LAT_MAX.
- w_stall_cnt  out  STALL_CNT_W  count of stall cycles.

## Operation
- A match on a source requires all of: the source is used, its address is nonzero, the producing stage is valid, the producer has wr_en set, and the addresses are equal.
- **Load-use hazard:** a D source matches E while w_e_is_load=1. Response: w_stall=1 and w_flush_e=1.
- **Memory wait:** w_mem_wait = w_m_valid & w_m_is_load & ~w_m_mem_ready, combinational.
  - w_mem_wait dominates: while it is 1, w_stall=1, w_flush_e=0, and no internal register updates except the wait FSM and the counter.
- **Forwarding selects:** computed from D sources against the E and M destinations. They are registered on clock edges where the pipe advances (no stall, no wait).
  - E match (non-load) -> 1.
  - Otherwise M match -> 2.
  - Otherwise -> 0.
  - E has priority over M (youngest producer wins).
- On a flush edge (w_flush_e=1 and no wait), both selects load 0.
- The register file is write-through, so a WB-stage producer needs no select.
- **Wait FSM:**
  - RUN -> WAIT when w_mem_wait=1.
  - WAIT -> RUN when w_m_mem_ready=1.
  - The wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches LOAD_LAT_MAX, w_mem_timeout sets. It is cleared only by reset.
  - The counter saturates and does not wrap.

## Timing
- Reset values: all outputs 0, FSM in RUN, counters 0.
- Reset assertion mid-wait returns the FSM to RUN immediately.
- w_stall, w_flush_e and w_mem_wait are combinational, same cycle as the condition.
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in M and the consumer's select registers 2.
- Selects become valid in the cycle the consumer occupies E, one edge after the D evaluation.
- When a load-use condition and w_mem_wait occur together, the wait applies first. The load-use bubble is inserted on the first cycle after the wait clears.

## Configuration
- HAZARD_PERF_CNT_EN defined: w_stall_cnt increments on every cycle with w_stall=1. It saturates at all-ones.
- HAZARD_PERF_CNT_EN undefined: the counter logic is absent and w_stall_cnt is tied to 0.

## Structure
- Package hazard_pkg holds:
  - FWD_NONE=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2.
  - The FSM state encoding ST_RUN/ST_WAIT.
- Sub-module hazard_src_cmp takes one source address plus the E and M producer info. It returns match_e, match_e_load and match_m. It is instantiated twice, once for rs and once for rt.

## Test plan
- add $3 in E; D reads rs=$3 -> no stall; next cycle w_fwd_rs_sel=1.
- lw $4 in E; D reads rt=$4 -> w_stall=1 and w_flush_e=1 for 1 cycle; next edge selects=0; following edge w_fwd_rt_sel=2.
- D reads $0 with E writing $0 -> no stall; selects remain 0.
- lw in M with w_m_mem_ready low for 3 cycles (LOAD_LAT_MAX=8) -> w_mem_wait=1 for 3 cycles; selects unchanged; w_mem_timeout stays 0.
- Ready held low for 8 cycles -> w_mem_timeout=1 and remains 1 after ready arrives; reset_n low clears it asynchronously.
- Both E and M write $5; D reads $5 -> select=1. With HAZARD_PERF_CNT_EN defined, run 2 stall cycles -> w_stall_cnt=2.

Source files
------------

// File: rtl/pipeline_hazard_unit_pkg.sv
// hazard_pkg: forwarding-select encodings, wait FSM state encoding and the
// per-operand select priority shared by the hazard unit.
package hazard_pkg;

    localparam logic [1:0] FWD_NONE = 2'd0;  // operand from the register file
    localparam logic [1:0] FWD_MEM  = 2'd1;  // operand from the M-stage result
    localparam logic [1:0] FWD_WB   = 2'd2;  // operand from the WB-stage result

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } wait_state_t;

    // Youngest producer wins: an E-stage match beats an M-stage match. An
    // E-stage load cannot forward (that case is handled by the bubble).
    function automatic logic [1:0] fwd_select(input logic match_e,
                                              input logic match_e_load,
                                              input logic match_m);
        if (match_e) begin
            return match_e_load ? FWD_NONE : FWD_MEM;
        end else if (match_m) begin
            return FWD_WB;
        end
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/pipeline_hazard_unit_src_cmp.sv
// hazard_src_cmp: compares one decode-stage source register against the
// E-stage and M-stage producers. Register 0 and unused sources never match.
module hazard_src_cmp
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  src_used,
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic                  e_valid,
    input  logic                  e_wr_en,
    input  logic                  e_is_load,
    input  logic [REG_ADDR_W-1:0] e_wr_addr,
    input  logic                  m_valid,
    input  logic                  m_wr_en,
    input  logic [REG_ADDR_W-1:0] m_wr_addr,
    output logic                  match_e,
    output logic                  match_e_load,
    output logic                  match_m
);

    logic src_live;

    // producer match per stage; a live source must be used and nonzero
    always_comb begin
        src_live     = src_used && (src_addr != '0);
        match_e      = src_live && e_valid && e_wr_en && (src_addr == e_wr_addr);
        match_e_load = match_e && e_is_load;
        match_m      = src_live && m_valid && m_wr_en && (src_addr == m_wr_addr);
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: load-use bubble, registered forwarding selects,
// variable-latency load freeze with a sticky timeout flag, and a stall counter.
// Optional feature: define HAZARD_PERF_CNT_EN to build the stall counter;
// otherwise w_stall_cnt is tied to zero.
module pipeline_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_LAT_MAX = 8,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   w_d_valid,
    input  logic                   w_d_uses_rs,
    input  logic                   w_d_uses_rt,
    input  logic [REG_ADDR_W-1:0]  w_d_rs_addr,
    input  logic [REG_ADDR_W-1:0]  w_d_rt_addr,
    input  logic                   w_e_valid,
    input  logic                   w_e_wr_en,
    input  logic                   w_e_is_load,
    input  logic [REG_ADDR_W-1:0]  w_e_wr_addr,
    input  logic                   w_m_valid,
    input  logic                   w_m_wr_en,
    input  logic                   w_m_is_load,
    input  logic [REG_ADDR_W-1:0]  w_m_wr_addr,
    input  logic                   w_m_mem_ready,
    output logic                   w_stall,
    output logic                   w_flush_e,
    output logic                   w_mem_wait,
    output logic [1:0]             w_fwd_rs_sel,
    output logic [1:0]             w_fwd_rt_sel,
    output logic                   w_mem_timeout,
    output logic [STALL_CNT_W-1:0] w_stall_cnt
);

    // Wait counter only needs to reach LOAD_LAT_MAX, where it saturates.
    localparam int                WCNT_W   = $clog2(LOAD_LAT_MAX + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(LOAD_LAT_MAX);

    logic rs_match_e, rs_match_e_load, rs_match_m;
    logic rt_match_e, rt_match_e_load, rt_match_m;
    logic load_use;

    logic [1:0]        fwd_rs_sel_q, fwd_rs_sel_d;
    logic [1:0]        fwd_rt_sel_q, fwd_rt_sel_d;
    wait_state_t       state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;

    hazard_src_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_rs_cmp (
        .src_used     (w_d_valid & w_d_uses_rs),
        .src_addr     (w_d_rs_addr),
        .e_valid      (w_e_valid),
        .e_wr_en      (w_e_wr_en),
        .e_is_load    (w_e_is_load),
        .e_wr_addr    (w_e_wr_addr),
        .m_valid      (w_m_valid),
        .m_wr_en      (w_m_wr_en),
        .m_wr_addr    (w_m_wr_addr),
        .match_e      (rs_match_e),
        .match_e_load (rs_match_e_load),
        .match_m      (rs_match_m)
    );

    hazard_src_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_rt_cmp (
        .src_used     (w_d_valid & w_d_uses_rt),
        .src_addr     (w_d_rt_addr),
        .e_valid      (w_e_valid),
        .e_wr_en      (w_e_wr_en),
        .e_is_load    (w_e_is_load),
        .e_wr_addr    (w_e_wr_addr),
        .m_valid      (w_m_valid),
        .m_wr_en      (w_m_wr_en),
        .m_wr_addr    (w_m_wr_addr),
        .match_e      (rt_match_e),
        .match_e_load (rt_match_e_load),
        .match_m      (rt_match_m)
    );

    // pipeline control: a pending load wait freezes everything and defers
    // any load-use bubble until the data returns
    always_comb begin
        load_use   = rs_match_e_load | rt_match_e_load;
        w_mem_wait = w_m_valid & w_m_is_load & ~w_m_mem_ready;
        w_stall    = w_mem_wait | load_use;
        w_flush_e  = load_use & ~w_mem_wait;
    end

    // next forwarding selects: hold on wait, clear on bubble, else track D
    always_comb begin
        fwd_rs_sel_d = fwd_rs_sel_q;
        fwd_rt_sel_d = fwd_rt_sel_q;
        if (!w_mem_wait) begin
            if (load_use) begin
                fwd_rs_sel_d = FWD_NONE;
                fwd_rt_sel_d = FWD_NONE;
            end else begin
                fwd_rs_sel_d = fwd_select(rs_match_e, rs_match_e_load, rs_match_m);
                fwd_rt_sel_d = fwd_select(rt_match_e, rt_match_e_load, rt_match_m);
            end
        end
    end

    // forwarding select registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fwd_rs_sel_q <= FWD_NONE;
            fwd_rt_sel_q <= FWD_NONE;
        end else begin
            fwd_rs_sel_q <= fwd_rs_sel_d;
            fwd_rt_sel_q <= fwd_rt_sel_d;
        end
    end

    // wait FSM next state; the counter holds the number of wait cycles seen
    // so far, including the cycle the wait started
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (w_mem_wait) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!w_mem_wait) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != WCNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
        if (wait_cnt_d == WCNT_MAX) begin
            timeout_d = 1'b1;
        end
    end

    // wait FSM, wait counter and sticky timeout registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign w_fwd_rs_sel  = fwd_rs_sel_q;
    assign w_fwd_rt_sel  = fwd_rt_sel_q;
    assign w_mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // count stall cycles, holding at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (w_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // stall counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign w_stall_cnt = stall_cnt_q;
`else
    assign w_stall_cnt = '0;
`endif

endmodule
